// File: rtl/aes_pkg.sv
// aes_pkg: shared constants and FSM state type for the AES S-box inverse datapath
package aes_pkg;
    localparam logic [7:0] AES_POLY_LO  = 8'h1B;
    localparam int         GF_INV_ITERS = 7;
    typedef enum logic [1:0] {IDLE, CALC, DONE} inv_state_e;
endpackage

// File: rtl/gf_mul8.sv
// gf_mul8: combinational GF(2^8) multiplier reduced by x^8+x^4+x^3+x+1
module gf_mul8
    import aes_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] p
);
    logic [7:0] t;
    // shift-and-add product; t walks a*x^i via xtime
    always_comb begin
        p = '0;
        t = a;
        for (int i = 0; i < 8; i++) begin
            p = b[i] ? (p ^ t) : p;
            t = {t[6:0], 1'b0} ^ (t[7] ? AES_POLY_LO : 8'h00);
        end
    end
endmodule

// File: rtl/gf_inv_seq.sv
// gf_inv_seq: iterative x^254 (multiplicative inverse) in GF(2^8) with valid/ready handshakes
module gf_inv_seq
    import aes_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data
);
    inv_state_e state_q, state_d;
    logic [7:0] sq_q, sq_d, acc_q, acc_d, sq_sq, acc_mul;
    logic [2:0] cnt_q, cnt_d;
    logic       accept;

    gf_mul8 u_sq  (.a(sq_q),  .b(sq_q),  .p(sq_sq));
    gf_mul8 u_acc (.a(acc_q), .b(sq_sq), .p(acc_mul));

    assign in_ready  = (state_q == IDLE) || (state_q == DONE && out_ready);
    assign out_valid = (state_q == DONE);
    assign out_data  = acc_q;

    // next state: load on accept, square-and-multiply in CALC, release on handoff
    always_comb begin
        state_d = state_q;
        sq_d    = sq_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        accept  = in_valid && in_ready;
        if (state_q == CALC) begin
            sq_d    = sq_sq;
            acc_d   = acc_mul;
            cnt_d   = cnt_q + 3'd1;
            state_d = (cnt_q == 3'(GF_INV_ITERS - 1)) ? DONE : CALC;
        end else if (accept) begin
            sq_d    = in_data;
            acc_d   = 8'h01;
            cnt_d   = '0;
            state_d = CALC;
        end else if (state_q == DONE && out_ready) begin
            state_d = IDLE;
        end
    end

    // state and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sq_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sq_q    <= sq_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_gf_inv_seq.sv
// tb_gf_inv_seq: self-checking bench for gf_inv_seq against a polynomial-arithmetic reference
module tb_gf_inv_seq;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready, out_valid;
    logic [7:0] out_data;
    int errors = 0;
    int checks = 0;

    gf_inv_seq dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0000;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (16'h011B << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] ref_inv(input logic [7:0] x);
        for (int r = 1; r < 256; r++) if (ref_mul(x, 8'(r)) == 8'h01) return 8'(r);
        return 8'h00;
    endfunction

    function automatic logic [7:0] ref_affine(input logic [7:0] x);
        logic [7:0] b;
        for (int i = 0; i < 8; i++)
            b[i] = x[i] ^ x[(i + 4) % 8] ^ x[(i + 5) % 8] ^ x[(i + 6) % 8] ^ x[(i + 7) % 8];
        return b ^ 8'h63;
    endfunction

    // starts just after a negedge, returns just after the negedge following the accept edge
    task automatic accept_op(input logic [7:0] x);
        in_valid = 1'b1;
        in_data  = x;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // edges counted from the accept edge until out_valid is seen; -1 if it never comes
    task automatic wait_valid(output int lat);
        lat = -1;
        for (int k = 0; k <= 20; k++) begin
            if (k > 0) @(negedge clk);
            if (out_valid) begin
                lat = k;
                return;
            end
        end
    endtask

    task automatic test_reset;
        #2;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 8'h00) begin
            errors++;
            $display("FAIL reset: in_ready=%b out_valid=%b out_data=%h, want 1 0 00", in_ready, out_valid, out_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_vectors;
        logic [7:0] xs [4] = '{8'h53, 8'h00, 8'h01, 8'h02};
        int lat;
        out_ready = 1'b1;
        foreach (xs[i]) begin
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL vec_ready x=%h: in_ready=%b want 1", xs[i], in_ready);
            end
            accept_op(xs[i]);
            wait_valid(lat);
            checks++;
            if (lat !== 7) begin
                errors++;
                $display("FAIL vec_latency x=%h: got %0d want 7", xs[i], lat);
            end
            checks++;
            if (out_data !== ref_inv(xs[i])) begin
                errors++;
                $display("FAIL vec_data x=%h: got %h want %h", xs[i], out_data, ref_inv(xs[i]));
            end
            if (xs[i] == 8'h53) begin
                checks++;
                if (ref_affine(out_data) !== 8'hED) begin
                    errors++;
                    $display("FAIL vec_sbox x=53: affine(%h)=%h want ed", out_data, ref_affine(out_data));
                end
            end
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL vec_release x=%h: out_valid=%b want 0", xs[i], out_valid);
            end
        end
    endtask

    task automatic test_backpressure;
        int lat;
        out_ready = 1'b0;
        accept_op(8'h53);
        wait_valid(lat);
        checks++;
        if (lat !== 7) begin
            errors++;
            $display("FAIL bp_latency: got %0d want 7", lat);
        end
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'hCA || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cycle %0d: valid=%b data=%h ready=%b want 1 ca 0", c, out_valid, out_data, in_ready);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_handoff_ready: in_ready=%b want 1", in_ready);
        end
        accept_op(8'h02);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drop: out_valid=%b want 0", out_valid);
        end
        wait_valid(lat);
        checks++;
        if (lat !== 7 || out_data !== 8'h8D) begin
            errors++;
            $display("FAIL bp_next: lat=%0d data=%h want 7 8d", lat, out_data);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_calc;
        int lat;
        out_ready = 1'b1;
        accept_op(8'h53);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset: valid=%b ready=%b data=%h want 0 1 00", out_valid, in_ready, out_data);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_hold: out_valid=%b want 0", out_valid);
        end
        rst_n = 1'b1;
        @(negedge clk);
        accept_op(8'h02);
        wait_valid(lat);
        checks++;
        if (lat !== 7 || out_data !== 8'h8D) begin
            errors++;
            $display("FAIL mid_reset_next: lat=%0d data=%h want 7 8d", lat, out_data);
        end
        @(negedge clk);
    endtask

    task automatic test_random;
        int lat, hold;
        logic [7:0] x, want;
        for (int n = 0; n < 24; n++) begin
            x    = 8'($urandom_range(0, 255));
            hold = $urandom_range(0, 3);
            want = ref_inv(x);
            out_ready = 1'b0;
            accept_op(x);
            wait_valid(lat);
            checks++;
            if (lat !== 7 || out_data !== want) begin
                errors++;
                $display("FAIL rand x=%h: lat=%0d data=%h want 7 %h", x, lat, out_data, want);
            end
            for (int c = 0; c < hold; c++) begin
                @(negedge clk);
                checks++;
                if (out_valid !== 1'b1 || out_data !== want) begin
                    errors++;
                    $display("FAIL rand_hold x=%h: valid=%b data=%h want 1 %h", x, out_valid, out_data, want);
                end
            end
            out_ready = 1'b1;
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL rand_release x=%h: valid=%b ready=%b want 0 1", x, out_valid, in_ready);
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back;
        bit early;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h00;
        for (int x = 0; x < 256; x++) begin
            @(posedge clk);
            @(negedge clk);
            if (x == 255) in_valid = 1'b0;
            else in_data = 8'(x + 1);
            early = 1'b0;
            for (int k = 1; k < 7; k++) begin
                if (out_valid !== 1'b0 || in_ready !== 1'b0) early = 1'b1;
                @(negedge clk);
            end
            @(negedge clk);
            checks++;
            if (early || out_valid !== 1'b1 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL sweep_timing x=%h: early=%b valid=%b ready=%b", 8'(x), early, out_valid, in_ready);
            end
            checks++;
            if (out_data !== ref_inv(8'(x))) begin
                errors++;
                $display("FAIL sweep_data x=%h: got %h want %h", 8'(x), out_data, ref_inv(8'(x)));
            end
            if (x != 0) begin
                checks++;
                if (ref_mul(8'(x), out_data) !== 8'h01) begin
                    errors++;
                    $display("FAIL sweep_product x=%h: x*%h=%h want 01", 8'(x), out_data, ref_mul(8'(x), out_data));
                end
            end
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL sweep_end: valid=%b ready=%b want 0 1", out_valid, in_ready);
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_backpressure();
        test_reset_mid_calc();
        test_random();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
